// File: rtl/weight_matrix_streamer.sv
// weight_matrix_streamer
//   Snapshots an N_ROWS x N_COLUMNS matrix of WIDTH-bit elements on start_i and
//   serialises it one element per valid/ready beat, row-major or column-major.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start_i      capture matrix_i / col_major_i and begin streaming (IDLE or DONE only)
//   col_major_i  0 = row-major order, 1 = column-major order
//   matrix_i     packed [N_ROWS-1:0][N_COLUMNS-1:0][WIDTH-1:0] source matrix
//   busy_o       streaming in progress
//   data_o       current element
//   row_o/col_o  indices of data_o
//   valid_o      beat valid
//   ready_i      sink accepts beat
//   eol_o        last element of the current row (row-major) / column (column-major)
//   last_o       final element of the matrix
//   done_o       one-cycle pulse after the final beat is accepted
module weight_matrix_streamer #(
    parameter int unsigned N_ROWS    = 4,
    parameter int unsigned N_COLUMNS = 4,
    parameter int unsigned WIDTH     = 8,
    localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    localparam int unsigned CW = (N_COLUMNS > 1) ? $clog2(N_COLUMNS) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start_i,
    input  logic                                         col_major_i,
    input  logic [N_ROWS-1:0][N_COLUMNS-1:0][WIDTH-1:0]  matrix_i,
    output logic                                         busy_o,
    output logic [WIDTH-1:0]                             data_o,
    output logic [RW-1:0]                                row_o,
    output logic [CW-1:0]                                col_o,
    output logic                                         valid_o,
    input  logic                                         ready_i,
    output logic                                         eol_o,
    output logic                                         last_o,
    output logic                                         done_o
);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;
    typedef logic [N_ROWS-1:0][N_COLUMNS-1:0][WIDTH-1:0] matrix_t;

    localparam logic [RW-1:0] RowLast = RW'(N_ROWS - 1);
    localparam logic [CW-1:0] ColLast = CW'(N_COLUMNS - 1);

    state_e           state_q, state_d;
    matrix_t          shadow_q, shadow_d;
    logic             col_major_q, col_major_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             eol_q, eol_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             handshake;
    logic             row_wrap;
    logic             col_wrap;
    logic             streaming_d;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        col_major_d = col_major_q;
        row_d       = row_q;
        col_d       = col_q;
        handshake   = valid_q & ready_i;
        row_wrap    = (row_q == RowLast);
        col_wrap    = (col_q == ColLast);

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    shadow_d    = matrix_i;
                    col_major_d = col_major_i;
                    row_d       = '0;
                    col_d       = '0;
                    state_d     = StStream;
                end else begin
                    state_d = StIdle;
                end
            end
            StStream: begin
                if (handshake) begin
                    if (row_wrap && col_wrap) begin
                        // Park indices at zero so idle outputs read as zero.
                        row_d   = '0;
                        col_d   = '0;
                        state_d = StDone;
                    end else if (!col_major_q) begin
                        if (col_wrap) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        if (row_wrap) begin
                            row_d = '0;
                            col_d = col_q + 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Output registers are loaded from next-state so every output is a flop.
        streaming_d = (state_d == StStream);
        valid_d     = streaming_d;
        data_d      = streaming_d ? shadow_d[row_d][col_d] : '0;
        eol_d       = streaming_d & (col_major_d ? (row_d == RowLast) : (col_d == ColLast));
        last_d      = streaming_d & (row_d == RowLast) & (col_d == ColLast);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            col_major_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            eol_q       <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            col_major_q <= col_major_d;
            row_q       <= row_d;
            col_q       <= col_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            eol_q       <= eol_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign busy_o  = valid_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign row_o   = row_q;
    assign col_o   = col_q;
    assign eol_o   = eol_q;
    assign last_o  = last_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_weight_matrix_streamer.sv
// tb_weight_matrix_streamer
//   Randomised self-checking bench: a 4x4x8 instance is checked beat by beat
//   against an order model computed from the beat count; a 1x1x16 instance
//   covers the degenerate single-beat matrix.
module tb_weight_matrix_streamer;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int W  = 8;
    localparam int NB = NR * NC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                         start, cm, ready;
    logic [NR-1:0][NC-1:0][W-1:0] matrix;
    logic                         busy, valid, eol, last, done;
    logic [W-1:0]                 data;
    logic [1:0]                   row, col;

    logic        start1, ready1;
    logic [15:0] matrix1;
    logic        busy1, valid1, eol1, last1, done1;
    logic [15:0] data1;
    logic        row1, col1;

    weight_matrix_streamer #(.N_ROWS(NR), .N_COLUMNS(NC), .WIDTH(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .col_major_i (cm),
        .matrix_i    (matrix),
        .busy_o      (busy),
        .data_o      (data),
        .row_o       (row),
        .col_o       (col),
        .valid_o     (valid),
        .ready_i     (ready),
        .eol_o       (eol),
        .last_o      (last),
        .done_o      (done)
    );

    weight_matrix_streamer #(.N_ROWS(1), .N_COLUMNS(1), .WIDTH(16)) u_dut_1x1 (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start1),
        .col_major_i (1'b0),
        .matrix_i    (matrix1),
        .busy_o      (busy1),
        .data_o      (data1),
        .row_o       (row1),
        .col_o       (col1),
        .valid_o     (valid1),
        .ready_i     (ready1),
        .eol_o       (eol1),
        .last_o      (last1),
        .done_o      (done1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the matrix as captured at start and the chosen order.
    logic [W-1:0] em [NR][NC];
    bit           ecm;

    // Called at a negedge: present a start with a fresh matrix.
    task automatic launch(input bit c, input bit pattern);
        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < NC; j++) begin
                matrix[i][j] = pattern ? W'(16 * i + j) : W'($urandom);
                em[i][j]     = matrix[i][j];
            end
        end
        ecm   = c;
        cm    = c;
        start = 1'b1;
    endtask

    // Walks beats 0..stop_after-1; mode 0 = ready high, 1 = random, 2 = 1,0,0 pattern.
    task automatic stream(input int mode, input bit mid, input int stop_after);
        int k = 0;
        int cyc = 0;
        int r, c;
        bit rdy;
        bit pulsed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (k < NB && k < stop_after && cyc < 400) begin
            r = ecm ? k % NR : k / NC;
            c = ecm ? k / NR : k % NC;
            check_eq("valid", 32'(valid), 32'd1);
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("done_in_stream", 32'(done), 32'd0);
            check_eq("data", 32'(data), 32'(em[r][c]));
            check_eq("row", 32'(row), 32'(r));
            check_eq("col", 32'(col), 32'(c));
            check_eq("eol", 32'(eol), 32'(ecm ? (r == NR - 1) : (c == NC - 1)));
            check_eq("last", 32'(last), 32'(k == NB - 1));
            rdy   = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
            ready = rdy;
            if (mid && k == 5 && !pulsed) begin
                pulsed = 1'b1;
                start  = 1'b1;
                cm     = ~ecm;
                matrix = '1;
            end
            @(negedge clk);
            start = 1'b0;
            if (rdy) k++;
            cyc++;
        end
        if (cyc >= 400) check_eq("stream_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_check(input bit idle_after);
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("valid_in_done", 32'(valid), 32'd0);
        check_eq("busy_in_done", 32'(busy), 32'd0);
        if (idle_after) begin
            @(negedge clk);
            check_eq("done_one_cycle", 32'(done), 32'd0);
            check_eq("valid_idle", 32'(valid), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"}, 32'(data), 32'd0);
        check_eq({tag, "_rowcol"}, 32'({row, col}), 32'd0);
        check_eq({tag, "_flags"}, 32'({valid, busy, eol, last, done}), 32'd0);
    endtask

    logic [15:0] v1;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        cm      = 1'b0;
        ready   = 1'b0;
        matrix  = '0;
        start1  = 1'b0;
        ready1  = 1'b0;
        matrix1 = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check_eq("reset_1x1", 32'({valid1, busy1, done1, data1}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_valid", 32'(valid), 32'd0);

        // Row-major then column-major with the 16*i+j pattern.
        launch(1'b0, 1'b1);
        stream(0, 1'b0, NB);
        finish_check(1'b1);
        launch(1'b1, 1'b1);
        stream(0, 1'b0, NB);
        finish_check(1'b1);

        // Backpressure 1,0,0 pattern.
        launch(1'b0, 1'b0);
        stream(2, 1'b0, NB);
        finish_check(1'b1);

        // Snapshot isolation and ignored mid-stream start.
        launch(1'b1, 1'b0);
        stream(1, 1'b1, NB);
        finish_check(1'b1);

        // Back-to-back: start presented during the DONE cycle.
        launch(1'b0, 1'b0);
        stream(0, 1'b0, NB);
        finish_check(1'b0);
        launch(1'b1, 1'b0);
        stream(0, 1'b0, NB);
        finish_check(1'b1);

        // Reset after 5 beats aborts with no done pulse; a fresh start restreams.
        launch(1'b0, 1'b0);
        stream(0, 1'b0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        @(negedge clk);
        check_eq("abort_no_done", 32'(done), 32'd0);
        launch(1'b1, 1'b0);
        stream(1, 1'b0, NB);
        finish_check(1'b1);

        // Random orders under random backpressure.
        repeat (4) begin
            launch(1'($urandom_range(0, 1)), 1'b0);
            stream(1, 1'b0, NB);
            finish_check(1'b1);
        end

        // 1x1 matrix: single beat with eol and last, held across a stall.
        v1      = 16'($urandom);
        matrix1 = v1;
        start1  = 1'b1;
        @(negedge clk);
        start1  = 1'b0;
        ready1  = 1'b0;
        matrix1 = ~v1;
        check_eq("1x1_valid", 32'(valid1), 32'd1);
        check_eq("1x1_data", 32'(data1), 32'(v1));
        check_eq("1x1_eol_last", 32'({eol1, last1}), 32'd3);
        check_eq("1x1_rowcol", 32'({row1, col1}), 32'd0);
        @(negedge clk);
        check_eq("1x1_stall_data", 32'(data1), 32'(v1));
        check_eq("1x1_stall_valid", 32'(valid1), 32'd1);
        check_eq("1x1_stall_done", 32'(done1), 32'd0);
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        check_eq("1x1_done", 32'(done1), 32'd1);
        check_eq("1x1_valid_after", 32'(valid1), 32'd0);
        @(negedge clk);
        check_eq("1x1_done_one_cycle", 32'(done1), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
